// File: rtl/uimac_tx_pfc_ctrl.sv
// MAC TX flow-control timer: one pause timer per PFC priority class, legacy PAUSE hits all classes.
// A class arms on a parsed frame, waits for a frame boundary, then holds its mask bit for the loaded count.

module uimac_tx_pfc_class #(
   parameter int QUANTA_W       = 16,
   parameter int CLK_PER_QUANTA = 64,
   parameter int LAT_COMP       = 0
) (
   input  logic                I_clk,
   input  logic                I_reset,
   input  logic                hit,
   input  logic [QUANTA_W-1:0] q,
   input  logic                boundary,
   output logic                paused,
   output logic                pending,
   output logic                idle,
   output logic                paused_nxt
);
   localparam int SH = $clog2(CLK_PER_QUANTA);
   localparam int CW = QUANTA_W + SH;

   typedef enum logic [1:0] {C_IDLE, C_PEND, C_PAUSE} cstate_t;

   cstate_t         state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [CW-1:0]   prod, load;
   logic            nz;

   assign nz   = |q;
   assign prod = CW'(q) << SH;
   // Latency compensation never lets a nonzero request collapse to zero cycles.
   assign load = (prod > CW'(LAT_COMP)) ? prod - CW'(LAT_COMP) : CW'(1);

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         state <= C_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         C_IDLE: begin
            if (hit && nz) begin
               state_nxt = C_PEND;
               cnt_nxt   = load;
            end
         end
         C_PEND: begin
            if (hit && !nz) begin
               state_nxt = C_IDLE;
               cnt_nxt   = '0;
            end else begin
               if (boundary) state_nxt = C_PAUSE;
               if (hit)      cnt_nxt   = load;
            end
         end
         C_PAUSE: begin
            // A nonzero hit always reloads, including on the expiry cycle, so the mask never gaps.
            if (hit && !nz) begin
               state_nxt = C_IDLE;
               cnt_nxt   = '0;
            end else if (hit) begin
               cnt_nxt   = load;
            end else if (cnt == CW'(1)) begin
               state_nxt = C_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = C_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      paused     = (state == C_PAUSE);
      pending    = (state == C_PEND);
      idle       = (state == C_IDLE);
      paused_nxt = (state_nxt == C_PAUSE);
   end
endmodule

module uimac_tx_pfc_ctrl #(
   parameter int                NUM_CLASS      = 8,
   parameter int                QUANTA_W       = 16,
   parameter int                CLK_PER_QUANTA = 64,
   parameter int                LAT_COMP       = 0,
   parameter int                ST_W           = 3,
   parameter logic [ST_W-1:0]   ST_IFG         = 3'd4,
   parameter logic [ST_W-1:0]   ST_IDLE        = 3'd0
) (
   input  logic                          I_clk,
   input  logic                          I_reset,
   input  logic [ST_W-1:0]               I_mac_state,
   input  logic                          I_pause_valid,
   input  logic                          I_pause_pfc,
   input  logic [NUM_CLASS-1:0]          I_pause_class_en,
   input  logic [NUM_CLASS*QUANTA_W-1:0] I_pause_quanta,
   input  logic [47:0]                   I_pause_addr,
   output logic [NUM_CLASS-1:0]          O_pause_mask,
   output logic                          O_pause_flag,
   output logic [NUM_CLASS-1:0]          O_pause_pending,
   output logic [47:0]                   O_pause_dst_mac_addr
);
   logic                 boundary;
   logic [NUM_CLASS-1:0] hit, nz_hit, idle, paused_nxt;

   assign boundary = (I_mac_state == ST_IFG) || (I_mac_state == ST_IDLE);

   for (genvar i = 0; i < NUM_CLASS; i++) begin : g_cls
      logic [QUANTA_W-1:0] q;
      assign hit[i]    = I_pause_valid && (!I_pause_pfc || I_pause_class_en[i]);
      assign q         = I_pause_pfc ? I_pause_quanta[i*QUANTA_W +: QUANTA_W]
                                     : I_pause_quanta[0 +: QUANTA_W];
      assign nz_hit[i] = hit[i] && (|q);

      uimac_tx_pfc_class #(
         .QUANTA_W       (QUANTA_W),
         .CLK_PER_QUANTA (CLK_PER_QUANTA),
         .LAT_COMP       (LAT_COMP)
      ) u_cls (
         .I_clk      (I_clk),
         .I_reset    (I_reset),
         .hit        (hit[i]),
         .q          (q),
         .boundary   (boundary),
         .paused     (O_pause_mask[i]),
         .pending    (O_pause_pending[i]),
         .idle       (idle[i]),
         .paused_nxt (paused_nxt[i])
      );
   end

   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         O_pause_flag         <= 1'b0;
         O_pause_dst_mac_addr <= '0;
      end else begin
         O_pause_flag <= |paused_nxt;
         if (|nz_hit)
            O_pause_dst_mac_addr <= I_pause_addr;
         else if (&idle)
            O_pause_dst_mac_addr <= '0;
      end
   end
endmodule

// File: tb/tb_uimac_tx_pfc_ctrl.sv
// Directed bench for uimac_tx_pfc_ctrl: legacy/PFC pause timing, boundary wait, refresh, zero resume, reset.
module tb_uimac_tx_pfc_ctrl;
   logic         I_clk = 1'b0;
   logic         I_reset = 1'b0;
   logic [2:0]   I_mac_state = 3'd0;
   logic         I_pause_valid = 1'b0;
   logic         I_pause_pfc = 1'b0;
   logic [7:0]   I_pause_class_en = '0;
   logic [127:0] I_pause_quanta = '0;
   logic [47:0]  I_pause_addr = '0;
   logic [7:0]   mask, pending, mask2, pending2;
   logic         flag, flag2;
   logic [47:0]  dst, dst2;
   int           n_cmp = 0;
   int           n_bad = 0;

   always #5 I_clk = ~I_clk;

   uimac_tx_pfc_ctrl dut (
      .I_clk(I_clk), .I_reset(I_reset), .I_mac_state(I_mac_state),
      .I_pause_valid(I_pause_valid), .I_pause_pfc(I_pause_pfc),
      .I_pause_class_en(I_pause_class_en), .I_pause_quanta(I_pause_quanta),
      .I_pause_addr(I_pause_addr), .O_pause_mask(mask), .O_pause_flag(flag),
      .O_pause_pending(pending), .O_pause_dst_mac_addr(dst));

   uimac_tx_pfc_ctrl #(.LAT_COMP(3)) dut2 (
      .I_clk(I_clk), .I_reset(I_reset), .I_mac_state(I_mac_state),
      .I_pause_valid(I_pause_valid), .I_pause_pfc(I_pause_pfc),
      .I_pause_class_en(I_pause_class_en), .I_pause_quanta(I_pause_quanta),
      .I_pause_addr(I_pause_addr), .O_pause_mask(mask2), .O_pause_flag(flag2),
      .O_pause_pending(pending2), .O_pause_dst_mac_addr(dst2));

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic do_reset();
      I_pause_valid = 1'b0;
      I_reset = 1'b1;
      #2;
      I_reset = 1'b0;
   endtask

   task automatic test_reset();
      I_reset = 1'b1;
      #2;
      n_cmp++; if (mask !== 8'h00)   begin n_bad++; $display("FAIL rst_mask got %h exp 00", mask); end
      n_cmp++; if (flag !== 1'b0)    begin n_bad++; $display("FAIL rst_flag got %b exp 0", flag); end
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rst_pending got %h exp 00", pending); end
      n_cmp++; if (dst !== 48'h0)    begin n_bad++; $display("FAIL rst_addr got %h exp 0", dst); end
      I_reset = 1'b0;
   endtask

   task automatic test_legacy(input string tag);
      int n;
      do_reset();
      I_mac_state = 3'd0;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b0; I_pause_class_en = 8'h00;
      I_pause_quanta = '0; I_pause_quanta[15:0] = 16'd2; I_pause_addr = 48'h0011_2233_4455;
      tick();
      I_pause_valid = 1'b0;
      n_cmp++; if (pending !== 8'hFF) begin n_bad++; $display("FAIL %s_pend got %h exp ff", tag, pending); end
      n_cmp++; if (mask !== 8'h00)    begin n_bad++; $display("FAIL %s_mask_t1 got %h exp 00", tag, mask); end
      tick();
      n_cmp++; if (mask !== 8'hFF) begin n_bad++; $display("FAIL %s_mask_t2 got %h exp ff", tag, mask); end
      n_cmp++; if (flag !== 1'b1)  begin n_bad++; $display("FAIL %s_flag_hi got %b exp 1", tag, flag); end
      n_cmp++; if (dst !== 48'h0011_2233_4455) begin n_bad++; $display("FAIL %s_addr got %h exp 001122334455", tag, dst); end
      n = 0;
      while (mask == 8'hFF && n < 400) begin n++; tick(); end
      n_cmp++; if (n !== 128)     begin n_bad++; $display("FAIL %s_len got %0d exp 128", tag, n); end
      n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL %s_mask_end got %h exp 00", tag, mask); end
      n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL %s_flag_lo got %b exp 0", tag, flag); end
      n_cmp++; if (dst !== 48'h0011_2233_4455) begin n_bad++; $display("FAIL %s_addr_hold got %h exp 001122334455", tag, dst); end
      tick();
      n_cmp++; if (dst !== 48'h0) begin n_bad++; $display("FAIL %s_addr_clr got %h exp 0", tag, dst); end
   endtask

   task automatic test_pfc_boundary();
      int n0, n2;
      do_reset();
      I_mac_state = 3'd1;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b1; I_pause_class_en = 8'h05;
      I_pause_quanta = '0; I_pause_quanta[15:0] = 16'd1; I_pause_quanta[47:32] = 16'd3;
      I_pause_addr = 48'hAABB_CCDD_EEFF;
      tick();
      I_pause_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (pending !== 8'h05 || mask !== 8'h00) begin
            n_bad++; $display("FAIL pfc_wait cyc %0d got pend %h mask %h exp 05/00", k, pending, mask);
         end
         tick();
      end
      I_mac_state = 3'd4;
      n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL pfc_bnd_cyc got %h exp 00", mask); end
      tick();
      n_cmp++; if (mask !== 8'h05 || pending !== 8'h00) begin
         n_bad++; $display("FAIL pfc_start got mask %h pend %h exp 05/00", mask, pending);
      end
      n0 = 1; n2 = 1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (mask[0]) n0++;
         if (mask[2]) n2++;
      end
      n_cmp++; if (n0 !== 64)  begin n_bad++; $display("FAIL pfc_len0 got %0d exp 64", n0); end
      n_cmp++; if (n2 !== 192) begin n_bad++; $display("FAIL pfc_len2 got %0d exp 192", n2); end
      n_cmp++; if (dst !== 48'h0) begin n_bad++; $display("FAIL pfc_addr_clr got %h exp 0", dst); end
   endtask

   task automatic test_refresh();
      int n;
      do_reset();
      I_mac_state = 3'd4;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b1; I_pause_class_en = 8'h08;
      I_pause_quanta = '0; I_pause_quanta[63:48] = 16'd1; I_pause_addr = 48'h1;
      tick();
      I_pause_valid = 1'b0;
      tick();
      n = 0;
      if (mask[3]) n++;
      for (int k = 0; k < 14; k++) begin tick(); if (mask[3]) n++; end
      n_cmp++; if (n !== 15) begin n_bad++; $display("FAIL refr_pre got %0d exp 15", n); end
      I_pause_valid = 1'b1;
      tick();
      I_pause_valid = 1'b0;
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL refr_nopend got %h exp 00", pending); end
      while (mask[3] && n < 400) begin n++; tick(); end
      n_cmp++; if (n !== 79) begin n_bad++; $display("FAIL refr_len got %0d exp 79", n); end
   endtask

   task automatic test_zero_resume();
      do_reset();
      I_mac_state = 3'd0;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b1; I_pause_class_en = 8'h02;
      I_pause_quanta = '0; I_pause_quanta[31:16] = 16'd2; I_pause_addr = 48'hC0FF_EE00_1234;
      tick();
      I_pause_valid = 1'b0;
      repeat (10) tick();
      n_cmp++; if (mask !== 8'h02) begin n_bad++; $display("FAIL zero_pre got %h exp 02", mask); end
      I_pause_valid = 1'b1; I_pause_quanta = '0;
      tick();
      I_pause_valid = 1'b0;
      n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL zero_mask got %h exp 00", mask); end
      n_cmp++; if (flag !== 1'b0)  begin n_bad++; $display("FAIL zero_flag got %b exp 0", flag); end
      n_cmp++; if (dst !== 48'hC0FF_EE00_1234) begin n_bad++; $display("FAIL zero_addr_hold got %h exp c0ffee001234", dst); end
      tick();
      n_cmp++; if (dst !== 48'h0) begin n_bad++; $display("FAIL zero_addr_clr got %h exp 0", dst); end
   endtask

   task automatic test_expiry();
      int n, n2;
      do_reset();
      I_mac_state = 3'd0;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b1; I_pause_class_en = 8'h01;
      I_pause_quanta = '0; I_pause_quanta[15:0] = 16'd1; I_pause_addr = 48'h2;
      tick();
      I_pause_valid = 1'b0;
      tick();
      n = 0; n2 = 0;
      if (mask[0]) n++;
      if (mask2[0]) n2++;
      for (int k = 0; k < 63; k++) begin
         tick();
         if (mask[0]) n++;
         if (mask2[0]) n2++;
      end
      n_cmp++; if (n2 !== 61) begin n_bad++; $display("FAIL latcomp_len got %0d exp 61", n2); end
      I_pause_valid = 1'b1;
      tick();
      I_pause_valid = 1'b0;
      while (mask[0] && n < 400) begin n++; tick(); end
      n_cmp++; if (n !== 128) begin n_bad++; $display("FAIL expiry_len got %0d exp 128", n); end
   endtask

   task automatic test_ignore();
      do_reset();
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b1; I_pause_class_en = 8'h00;
      I_pause_quanta = {8{16'd5}}; I_pause_addr = 48'hDEAD_BEEF_0001;
      tick();
      I_pause_valid = 1'b0;
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL ign_pend got %h exp 00", pending); end
      n_cmp++; if (dst !== 48'h0)     begin n_bad++; $display("FAIL ign_addr got %h exp 0", dst); end
      tick();
      n_cmp++; if (mask !== 8'h00)    begin n_bad++; $display("FAIL ign_mask got %h exp 00", mask); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      I_mac_state = 3'd0;
      tick();
      I_pause_valid = 1'b1; I_pause_pfc = 1'b0;
      I_pause_quanta = '0; I_pause_quanta[15:0] = 16'd2; I_pause_addr = 48'h3;
      tick();
      I_pause_valid = 1'b0;
      repeat (21) tick();
      n_cmp++; if (mask !== 8'hFF) begin n_bad++; $display("FAIL mid_pre got %h exp ff", mask); end
      #3;
      I_reset = 1'b1;
      #1;
      n_cmp++; if (mask !== 8'h00 || flag !== 1'b0 || pending !== 8'h00 || dst !== 48'h0) begin
         n_bad++; $display("FAIL mid_rst got mask %h flag %b pend %h addr %h exp all 0", mask, flag, pending, dst);
      end
      #1;
      I_reset = 1'b0;
      test_legacy("relaunch");
   endtask

   initial begin
      test_reset();
      test_legacy("legacy");
      test_pfc_boundary();
      test_refresh();
      test_zero_resume();
      test_expiry();
      test_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
